fp_result_collector: RTL
========================

// Module: fp_result_collector
// PURPOSE
// Write-back/consumer end of the Top_Add_Sub adder interface. The adder has no stall.
// Each cycle the block captures the unpacked adder result (Sz/Ez/Mz_final plus 5 IEEE flags).
// It packs the result into a 32-bit IEEE-754 single, buffers it in a FIFO and presents it on a
// valid/ready port. It also keeps sticky exception flags, an overrun flag and a result counter.
// PARAMETERS
// DEPTH      8   FIFO entries; power of 2, >= 2
// CANON_NAN  1   1: any NaN result is replaced by 32'h7FC00000; 0: NaN passed bit-exact
// CNT_W      16  width of result counter
// PORTS
// clk         in   1      clock, all state on rising edge
// rst         in   1      synchronous reset, active-high
// in_valid    in   1      adder result valid this cycle
// Sz          in   1      result sign
// Ez          in   8      result biased exponent
// Mz_final    in   23     result fraction
// in_flags    in   5      {invalid,overflow,underflow,inexact,zero} for this result
// in_ready    out  1      FIFO can accept; advisory only, adder does not stall
// out_valid   out  1      FIFO head valid
// out_ready   in   1      consumer accepts head
// out_data    out  32     packed result {S,E,M} at FIFO head
// out_flags   out  5      flags stored with head entry
// flags_clr   in   1      clear sticky flags and overrun
// fflags      out  5      sticky OR of flags of all accepted results since clear/reset
// overrun     out  1      sticky: a valid result was dropped because FIFO full
// result_cnt  out  CNT_W  number of accepted results, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Clock is clk; reset is synchronous and active-high on rst.
// - Reset state: FIFO empty, out_valid=0, out_data=0, out_flags=0, fflags=0, overrun=0,
//   result_cnt=0, in_ready=1.
// - Packing (combinational, ahead of the FIFO write): word = {Sz,Ez,Mz_final}.
//   If CANON_NAN=1, Ez==8'hFF and Mz_final!=0, then word=32'h7FC00000; the sign is discarded.
// - FIFO pointers are log2(DEPTH)+1 bits; the extra MSB separates full from empty.
//   full = (wr ^ rd) == {1'b1,0...}; empty = wr == rd.
// - pop = out_valid & out_ready. push = in_valid & (!full | pop).
// - Full with simultaneous pop: the push is accepted.
// - in_ready = !full (registered-state based; it does not depend on out_ready).
// - Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. No same-cycle bypass.
// - The head is held stable while out_valid & !out_ready. out_data/out_flags change only after a pop.
// - Drop: in_valid & full & !pop -> the result is discarded and overrun<=1.
//   FIFO, fflags and result_cnt are unchanged.
// - Sticky: fflags <= (flags_clr ? 0 : fflags) | (push ? in_flags : 0).
//   overrun uses the same rule, with "drop" as its set term.
//   Set wins over a same-cycle clear.
// - result_cnt increments by 1 per push and wraps from all-ones to 0. flags_clr does not clear it.
// - in_valid=0: Sz/Ez/Mz_final/in_flags are don't-care and produce no effect.
// - Reset mid-operation: FIFO contents are discarded; all outputs return to their reset values
//   on the next edge.
// TESTING
// - Reset: hold rst 2 cycles with in_valid=1 -> after release out_valid=0, fflags=0,
//   result_cnt=0, nothing captured during reset.
// - Normal: S=0,E=8'h82,M=23'h1C0000,flags=0, out_ready=1 -> next cycle out_valid=1,
//   out_data=32'h411C0000; cnt=1.
// - NaN: E=8'hFF,M=23'h000208,flags=5'b10000 -> out_data=32'h7FC00000,
//   out_flags=5'b10000, fflags=5'b10000.
//   Same stimulus with CANON_NAN=0 -> out_data=32'h7F800208.
// - +Inf/overflow: S=0,E=8'hFF,M=0,flags=5'b01000 -> out_data=32'h7F800000.
//   Then a result with flags 5'b00010 -> fflags=5'b01010.
//   Assert flags_clr with a concurrent push of flags 5'b00001 -> fflags=5'b00001.
// - Full/overrun: out_ready=0, push DEPTH+1 results -> in_ready=0 after the DEPTH-th push,
//   overrun=1, cnt=DEPTH. Draining yields exactly the first DEPTH words in order.
// - Full+pop: FIFO full, out_ready=1 and in_valid=1 in the same cycle -> push accepted,
//   overrun stays 0, occupancy stays DEPTH, order preserved.

Source files
------------

// File: rtl/fp_result_collector.sv
// Write-back end of the adder: packs each unpacked result into an IEEE-754 single,
// queues it in a FIFO, and keeps sticky exception flags, an overrun flag and a result count.
module fp_result_collector #(
  parameter int unsigned DEPTH     = 8,
  parameter bit          CANON_NAN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             Sz,
  input  logic [7:0]       Ez,
  input  logic [22:0]      Mz_final,
  input  logic [4:0]       in_flags,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_flags,
  input  logic             flags_clr,
  output logic [4:0]       fflags,
  output logic             overrun,
  output logic [CNT_W-1:0] result_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Handshake: a head entry transfers on a cycle where out_valid & out_ready are both high;
  // out_data/out_flags stay stable while out_valid is high and out_ready is low. in_ready is
  // advisory: the producer never stalls, so a result arriving while full is dropped.

  logic [31:0]      data_mem_q [DEPTH];
  logic [4:0]       flag_mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        full, empty, push, pop, drop;
  logic [31:0] word;

  assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign empty = (wr_q == rd_q);
  assign pop   = !empty && out_ready;
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && full && !pop;

  always_comb begin
    word = {Sz, Ez, Mz_final};
    if (CANON_NAN && (Ez == 8'hFF) && (Mz_final != 23'd0)) begin
      word = 32'h7FC0_0000;
    end
  end

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    fflags_d  = (flags_clr ? 5'd0 : fflags_q) | (push ? in_flags : 5'd0);
    overrun_d = (flags_clr ? 1'b0 : overrun_q) | drop;
    if (push) begin
      wr_d  = wr_q + {{AW{1'b0}}, 1'b1};
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      fflags_q  <= '0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      fflags_q  <= fflags_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      data_mem_q[wr_q[AW-1:0]] <= word;
      flag_mem_q[wr_q[AW-1:0]] <= in_flags;
    end
  end

  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_data   = empty ? 32'd0 : data_mem_q[rd_q[AW-1:0]];
  assign out_flags  = empty ? 5'd0  : flag_mem_q[rd_q[AW-1:0]];
  assign fflags     = fflags_q;
  assign overrun    = overrun_q;
  assign result_cnt = cnt_q;

endmodule
